// File: rtl/vga_timing_pkg.sv
// Shared types and default 2400x1400 timing for the VGA timing controller.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  localparam int unsigned DEF_W      = 12;
  localparam int unsigned DEF_H_ACT  = 1920;
  localparam int unsigned DEF_H_FP   = 88;
  localparam int unsigned DEF_H_SYNC = 44;
  localparam int unsigned DEF_H_BP   = 348;
  localparam int unsigned DEF_V_ACT  = 1080;
  localparam int unsigned DEF_V_FP   = 4;
  localparam int unsigned DEF_V_SYNC = 5;
  localparam int unsigned DEF_V_BP   = 311;

  localparam int unsigned H_TOTAL = DEF_H_ACT + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_timing_ctrl_axis.sv
// One timing axis: counter 0..TOTAL-1 with registered ACTIVE/FRONT/SYNC/BACK phase.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACT  = DEF_H_ACT,
  parameter int unsigned FP   = DEF_H_FP,
  parameter int unsigned SYNC = DEF_H_SYNC,
  parameter int unsigned BP   = DEF_H_BP,
  parameter int unsigned W    = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_step,
  output logic [W-1:0] o_cnt,
  output phase_t       o_phase,
  output logic         o_wrap
);

  localparam int unsigned TOTAL = ACT + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] B_FRONT = W'(ACT);
  localparam logic [W-1:0] B_SYNC  = W'(ACT + FP);
  localparam logic [W-1:0] B_BACK  = W'(ACT + FP + SYNC);

  if (ACT == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_phase
    $error("vga_axis_fsm: every phase must be at least one unit wide");
  end
  if ((64'd1 << W) <= 64'(TOTAL)) begin : g_bad_width
    $error("vga_axis_fsm: counter width too small for TOTAL");
  end

  logic [W-1:0] cnt_nxt;
  assign cnt_nxt = o_cnt + W'(1);
  assign o_wrap  = i_step && (o_cnt == LAST);

  // Phase moves on the same edge the count lands on a boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_cnt   <= '0;
      o_phase <= PH_ACTIVE;
    end else if (i_step) begin
      if (o_cnt == LAST) begin
        o_cnt   <= '0;
        o_phase <= PH_ACTIVE;
      end else begin
        o_cnt <= cnt_nxt;
        if (cnt_nxt == B_FRONT)     o_phase <= PH_FRONT;
        else if (cnt_nxt == B_SYNC) o_phase <= PH_SYNC;
        else if (cnt_nxt == B_BACK) o_phase <= PH_BACK;
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: run/stop FSM with frame-aligned stop over a pixel/line axis pair.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned H_ACT    = DEF_H_ACT,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACT    = DEF_V_ACT,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic         o_busy,
  output logic [W-1:0] o_hcnt,
  output logic [W-1:0] o_vcnt,
  output logic         o_hsync,
  output logic         o_vsync,
  output logic         o_de,
  output logic         o_sol,
  output logic         o_sof
);

  run_state_t   state;
  logic         stop_pending;
  logic         run;
  logic [W-1:0] h_cnt, v_cnt;
  phase_t       h_phase, v_phase;
  logic         h_wrap, v_wrap;

  assign run = (state == ST_RUN);

  vga_axis_fsm #(.ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(W)) u_h_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (!run),
    .i_step (run),
    .o_cnt  (h_cnt),
    .o_phase(h_phase),
    .o_wrap (h_wrap)
  );

  vga_axis_fsm #(.ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(W)) u_v_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (!run),
    .i_step (h_wrap),
    .o_cnt  (v_cnt),
    .o_phase(v_phase),
    .o_wrap (v_wrap)
  );

  // stop_pending tracks the most recent i_en seen while running; it only acts at frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          stop_pending <= 1'b0;
          if (i_en) state <= ST_RUN;
        end
        ST_RUN: begin
          stop_pending <= !i_en;
          if (v_wrap && stop_pending) begin
            state        <= ST_IDLE;
            stop_pending <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every output is a single-gate decode of the same registered state, so all describe one pixel.
  always_comb begin
    o_busy  = run;
    o_hcnt  = h_cnt;
    o_vcnt  = v_cnt;
    o_hsync = (run && h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    o_vsync = (run && v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    o_de    = run && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    o_sol   = run && (h_cnt == '0);
    o_sof   = run && (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a reduced 17x10 raster with active-low sync.
module tb_vga_timing_ctrl;

  // Reduced timing: H = 8+2+3+4 = 17, V = 4+1+2+3 = 10, frame = 170 cycles.
  localparam int H_T   = 17;
  localparam int V_T   = 10;
  localparam int FRAME = 170;
  localparam int HS_LO = 10;  // hsync pixels 10..12
  localparam int HS_HI = 12;
  localparam int VS_LO = 5;   // vsync lines 5..6
  localparam int VS_HI = 6;
  localparam int SP    = 0;   // asserted sync level

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en  = 1'b0;
  logic       o_busy, o_hsync, o_vsync, o_de, o_sol, o_sof;
  logic [5:0] o_hcnt, o_vcnt;

  int checks = 0;
  int errors = 0;
  int de_line0, hs_line0, sol_cnt, sof_cnt;

  vga_timing_ctrl #(
    .W(6), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .o_busy (o_busy),
    .o_hcnt (o_hcnt),
    .o_vcnt (o_vcnt),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_de   (o_de),
    .o_sol  (o_sol),
    .o_sof  (o_sof)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Compare every output against the expected raster position k (or idle values).
  task automatic expect_cycle(input bit run_exp, input int k);
    int h, v, hs, vs, de;
    h  = run_exp ? k % H_T : 0;
    v  = run_exp ? (k / H_T) % V_T : 0;
    hs = (run_exp && h >= HS_LO && h <= HS_HI) ? SP : 1 - SP;
    vs = (run_exp && v >= VS_LO && v <= VS_HI) ? SP : 1 - SP;
    de = (run_exp && h < 8 && v < 4) ? 1 : 0;
    check_val($sformatf("busy@%0d", k), int'(o_busy), int'(run_exp));
    check_val($sformatf("hcnt@%0d", k), int'(o_hcnt), h);
    check_val($sformatf("vcnt@%0d", k), int'(o_vcnt), v);
    check_val($sformatf("hsync@%0d", k), int'(o_hsync), hs);
    check_val($sformatf("vsync@%0d", k), int'(o_vsync), vs);
    check_val($sformatf("de@%0d", k), int'(o_de), de);
    check_val($sformatf("sol@%0d", k), int'(o_sol), (run_exp && h == 0) ? 1 : 0);
    check_val($sformatf("sof@%0d", k), int'(o_sof), (run_exp && h == 0 && v == 0) ? 1 : 0);
  endtask

  initial begin
    int k;
    de_line0 = 0; hs_line0 = 0; sol_cnt = 0; sof_cnt = 0;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    expect_cycle(1'b0, 0);
    @(negedge i_clk);
    expect_cycle(1'b0, 0);

    // Start: first RUN cycle must present pixel (0,0) with sof.
    i_en = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge i_clk);
      expect_cycle(1'b1, k);
      if (k < H_T) begin
        de_line0 += int'(o_de);
        if (o_hsync == 1'(SP)) hs_line0++;
      end
      sol_cnt += int'(o_sol);
      sof_cnt += int'(o_sof);
      k++;
    end
    check_val("de_cycles_line0", de_line0, 8);
    check_val("hsync_cycles_line0", hs_line0, 3);
    check_val("sol_pulses_2frames", sol_cnt, 2 * V_T);
    check_val("sof_pulses_2frames", sof_cnt, 2);

    // Drop then re-raise i_en mid-frame: must not stop.
    for (int i = 0; i < FRAME; i++) begin
      @(negedge i_clk);
      expect_cycle(1'b1, k);
      if (k % FRAME == 6 * H_T + 5) i_en = 1'b0;
      if (k % FRAME == 8 * H_T + 3) i_en = 1'b1;
      k++;
    end

    // Drop i_en mid-frame and hold: frame completes, then IDLE without sof.
    for (int i = 0; i < FRAME; i++) begin
      @(negedge i_clk);
      expect_cycle(1'b1, k);
      if (k % FRAME == 6 * H_T + 5) i_en = 1'b0;
      k++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      expect_cycle(1'b0, 0);
    end

    // Restart, then synchronous reset mid-frame at (4,2).
    i_en = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * H_T + 5; i++) begin
      @(negedge i_clk);
      expect_cycle(1'b1, k);
      k++;
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    expect_cycle(1'b0, 0);
    i_rst = 1'b0;
    k = 0;
    for (int i = 0; i < H_T + 2; i++) begin
      @(negedge i_clk);
      expect_cycle(1'b1, k);
      k++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
